// File: rtl/uart_loader_gpio_top.sv
// uart_loader_gpio_top: UART 8N1 receiver feeding a little-endian word loader into instruction RAM,
// then sensor-driven one-hot GPIO decisions once the program load is complete.
module uart_loader_gpio_top #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BIT_RATE  = 9600,
    parameter int MEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data,
    input  logic [2:0] input_gpio_pins,
    output logic [3:0] output_gpio_pins,
    output logic       write_done
);
    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [31:0]   r_word;
    logic [1:0]    r_k;
    logic          r_full;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_mem [MEM_WORDS];
    logic          w_rxd;
    logic [3:0]    w_gpio;

    assign w_rxd  = r_sync[1];
    assign w_gpio = input_gpio_pins[0]            ? 4'b0001 :
                    input_gpio_pins[2:1] == 2'b10 ? 4'b0010 :
                    input_gpio_pins[2:1] == 2'b01 ? 4'b0100 :
                    input_gpio_pins[2:1] == 2'b00 ? 4'b1000 : 4'b0000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync        <= 2'b11;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= 8'h00;
        end else begin
            r_sync        <= {r_sync[0], uart_rxd};
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            if (!uart_rx_en) r_state <= S_IDLE;
            else case (r_state)
                S_IDLE: if (!w_rxd) begin
                    r_state <= S_START;
                    r_cnt   <= '0;
                end
                S_START: if (r_cnt == CW'(HALF - 1)) begin
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_state <= w_rxd ? S_IDLE : S_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                S_DATA: if (r_cnt == CW'(CPB - 1)) begin
                    r_cnt   <= '0;
                    r_shift <= {w_rxd, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state <= S_STOP;
                end else r_cnt <= r_cnt + 1'b1;
                S_STOP: if (r_cnt == CW'(CPB - 1)) begin
                    r_state <= S_IDLE;
                    if (w_rxd) begin
                        uart_rx_data  <= r_shift;
                        uart_rx_valid <= 1'b1;
                    end else if (r_shift == 8'h00) uart_rx_break <= 1'b1;
                end else r_cnt <= r_cnt + 1'b1;
            endcase
        end
    end

    // A completed word is flagged by r_full and committed one cycle after its 4th byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_word           <= '0;
            r_k              <= '0;
            r_full           <= 1'b0;
            r_addr           <= '0;
            write_done       <= 1'b0;
            output_gpio_pins <= 4'b0000;
        end else begin
            output_gpio_pins <= write_done ? w_gpio : 4'b0000;
            r_full           <= 1'b0;
            if (uart_rx_break) r_k <= '0;
            else if (uart_rx_valid && !write_done) begin
                r_word[{r_k, 3'b000} +: 8] <= uart_rx_data;
                r_k                        <= r_k + 2'd1;
                r_full                     <= r_k == 2'd3;
            end
            if (r_full) begin
                if (r_word == 32'hFFFF_FFFF) write_done <= 1'b1;
                else begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == AW'(MEM_WORDS - 1)) write_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && r_full && r_word != 32'hFFFF_FFFF) r_mem[r_addr] <= r_word;
    end
endmodule

// File: tb/tb_uart_loader_gpio_top.sv
// tb_uart_loader_gpio_top: directed UART frames against a byte/word-level model of the loader and GPIO table.
module tb_uart_loader_gpio_top;
    localparam int CPB = 10;
    localparam int MW  = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic [2:0] input_gpio_pins = 3'b000;
    logic [3:0] output_gpio_pins;
    logic       write_done;

    int checks = 0;
    int failures = 0;

    int          exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] m_mem [MW];
    bit          mem_known [MW];
    int          m_addr = 0;
    bit          m_wd = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic [3:0]  exp_gpio = 4'b0000;
    int          settle = 2;
    int          ev;
    logic [31:0] w;

    logic [3:0] gpio_tab [8] = '{4'b1000, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0001};
    logic [2:0] pin_v [5] = '{3'b101, 3'b100, 3'b010, 3'b000, 3'b110};
    logic [3:0] gp_v  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    uart_loader_gpio_top #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .MEM_WORDS(MW)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .uart_rx_break(uart_rx_break), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .input_gpio_pins(input_gpio_pins), .output_gpio_pins(output_gpio_pins), .write_done(write_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ev: byte value for an expected good frame, 256 for a break, -1 for no pulse at all.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int e, input int abort_bit = -1);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (e >= 0) exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i == abort_bit) uart_rx_en = 1'b0;
            uart_rxd = bits[i];
            tick(CPB);
        end
        uart_rxd = 1'b1;
        tick(3 * CPB);
        uart_rx_en = 1'b1;
        chk("frame_events_consumed", exp_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, int'(b));
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            m_wd = 1'b0;
            bq.delete();
            m_addr = 0;
            m_data = 8'h00;
            exp_gpio = 4'b0000;
            settle = 2;
        end else begin
            if (settle == 0) begin
                chk("write_done", write_done, m_wd);
                chk("gpio", output_gpio_pins, exp_gpio);
            end else settle--;
            exp_gpio = m_wd ? gpio_tab[input_gpio_pins] : 4'b0000;
            if (uart_rx_valid || uart_rx_break) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: valid=%b break=%b data=%h expected no pulse", uart_rx_valid, uart_rx_break, uart_rx_data);
                end else begin
                    ev = exp_q.pop_front();
                    chk("pulse_kind", {uart_rx_break, uart_rx_valid}, (ev == 256) ? 2'b10 : 2'b01);
                    if (ev == 256) bq.delete();
                    else begin
                        m_data = ev[7:0];
                        settle = 4;
                        if (!m_wd) begin
                            bq.push_back(ev[7:0]);
                            if (bq.size() == 4) begin
                                w = {bq[3], bq[2], bq[1], bq[0]};
                                bq.delete();
                                if (w == 32'hFFFF_FFFF) m_wd = 1'b1;
                                else begin
                                    m_mem[m_addr] = w;
                                    mem_known[m_addr] = 1'b1;
                                    if (m_addr == MW - 1) m_wd = 1'b1;
                                    else m_addr++;
                                end
                            end
                        end
                    end
                end
            end
            chk("rx_data", uart_rx_data, m_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick(400);
        chk("rst_valid", uart_rx_valid, 1'b0);
        chk("rst_break", uart_rx_break, 1'b0);
        chk("rst_data", uart_rx_data, 8'h00);
        chk("rst_gpio", output_gpio_pins, 4'b0000);
        chk("rst_write_done", write_done, 1'b0);
        resetn = 1'b1;
        uart_rx_en = 1'b1;
        tick(5);
        send_byte(8'hA5);
        chk("data_A5", uart_rx_data, 8'hA5);
        tick(20);
        chk("data_A5_held", uart_rx_data, 8'hA5);
        send_frame(8'h00, 1'b0, 256);
        chk("break_keeps_data", uart_rx_data, 8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(8'h00, 1'b0, 256);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("ram0_break_resync", dut.r_mem[0], 32'h66554433);
        chk("addr_after_word0", dut.r_addr, 1);
        send_frame(8'h5A, 1'b0, -1);
        chk("framing_err_data_kept", uart_rx_data, 8'h66);
        send_frame(8'h77, 1'b1, -1, 4);
        chk("abort_data_kept", uart_rx_data, 8'h66);
        send_byte(8'h13);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hFB);
        chk("ram1_word", dut.r_mem[1], 32'hFB010113);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF);
            if (i == 2) chk("wd_before_last_ff", write_done, 1'b0);
        end
        chk("wd_after_end_word", write_done, 1'b1);
        chk("addr_after_end_word", dut.r_addr, 2);
        for (int i = 0; i < 5; i++) begin
            input_gpio_pins = pin_v[i];
            tick(1);
            chk("gpio_table", output_gpio_pins, gp_v[i]);
        end
        send_byte(8'h99);
        chk("late_byte_shown", uart_rx_data, 8'h99);
        chk("late_byte_not_stored", dut.r_addr, 2);
        uart_rxd = 1'b0;
        tick(CPB + 3);
        resetn = 1'b0;
        uart_rxd = 1'b1;
        tick(5);
        resetn = 1'b1;
        tick(5);
        chk("midframe_rst_wd", write_done, 1'b0);
        chk("midframe_rst_data", uart_rx_data, 8'h00);
        chk("midframe_rst_gpio", output_gpio_pins, 4'b0000);
        send_byte(8'h3C);
        chk("post_rst_3C", uart_rx_data, 8'h3C);
        chk("post_rst_wd", write_done, 1'b0);
        send_frame(8'h00, 1'b0, 256);
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i));
            if (i == 12) chk("wd_before_full", write_done, 1'b0);
        end
        chk("wd_ram_full", write_done, 1'b1);
        chk("ram3_full", dut.r_mem[3], 32'h100F0E0D);
        chk("ram0_overwritten", dut.r_mem[0], 32'h04030201);
        send_byte(8'h77);
        chk("after_full_byte", uart_rx_data, 8'h77);
        for (int i = 0; i < MW; i++)
            if (mem_known[i]) chk("ram_model", dut.r_mem[i], m_mem[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
